control_sequencer: RTL

//  Ring-counter timing and control-word generator for the SAP core. Consumes the

---
 rtl/control_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : control_sequencer
// Description : One-hot T1..T6 ring counter and control-word generator for the
//               SAP core; owns fetch, execute and halt sequencing.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module control_sequencer #(
    parameter bit EARLY_END = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       lda,
    input  logic       add,
    input  logic       sub,
    input  logic       out,
    input  logic       hlt,
    output logic [5:0] t_state,
    output logic       halted,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       out_load
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    tstate_e state_q, state_d;
    logic    halted_q, halted_d;

    // Priority decode: hlt (active-low) > lda > add > sub > out
    logic dec_hlt, dec_lda, dec_add, dec_sub, dec_out, dec_arith, active;

    assign dec_hlt   = ~hlt;
    assign dec_lda   = hlt & lda;
    assign dec_add   = hlt & ~lda & add;
    assign dec_sub   = hlt & ~lda & ~add & sub;
    assign dec_out   = hlt & ~lda & ~add & ~sub & out;
    assign dec_arith = dec_add | dec_sub;
    assign active    = run & ~halted_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= T1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        pc_out   = 1'b0;
        pc_inc   = 1'b0;
        mar_load = 1'b0;
        ram_out  = 1'b0;
        ir_load  = 1'b0;
        ir_out   = 1'b0;
        a_load   = 1'b0;
        a_out    = 1'b0;
        b_load   = 1'b0;
        alu_out  = 1'b0;
        alu_sub  = 1'b0;
        out_load = 1'b0;

        if (active) begin
            case (state_q)
                T1: begin
                    pc_out   = 1'b1;
                    mar_load = 1'b1;
                    state_d  = T2;
                end
                T2: begin
                    pc_inc  = 1'b1;
                    state_d = T3;
                end
                T3: begin
                    ram_out = 1'b1;
                    ir_load = 1'b1;
                    state_d = T4;
                end
                T4: begin
                    if (dec_hlt) begin
                        halted_d = 1'b1;
                        state_d  = T1;
                    end else if (dec_lda || dec_arith) begin
                        ir_out   = 1'b1;
                        mar_load = 1'b1;
                        state_d  = T5;
                    end else begin
                        // OUT and NOP share the same early-exit point
                        a_out    = dec_out;
                        out_load = dec_out;
                        state_d  = EARLY_END ? T1 : T5;
                    end
                end
                T5: begin
                    if (dec_lda) begin
                        ram_out = 1'b1;
                        a_load  = 1'b1;
                    end else if (dec_arith) begin
                        ram_out = 1'b1;
                        b_load  = 1'b1;
                    end
                    state_d = (EARLY_END && !dec_arith) ? T1 : T6;
                end
                T6: begin
                    alu_out = dec_arith;
                    a_load  = dec_arith;
                    alu_sub = dec_sub;
                    state_d = T1;
                end
                default: state_d = T1;
            endcase
        end
    end

    assign t_state = state_q;
    assign halted  = halted_q;

endmodule
`default_nettype wire
